// File: rtl/uart_transmitter_pkg.sv
// Shared UART TX definitions: FIFO geometry, LCR bit positions, FSM state codes
// and the frame helpers used by the transmitter.
package uart_transmitter_pkg;

    localparam int UART_FIFO_WIDTH     = 8;
    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_POINTER_W = 4;
    localparam int UART_FIFO_COUNTER_W = 5;

    localparam int UART_LC_SB = 2;
    localparam int UART_LC_PE = 3;
    localparam int UART_LC_EP = 4;
    localparam int UART_LC_SP = 5;
    localparam int UART_LC_BC = 6;

    typedef enum logic [2:0] {
        s_idle        = 3'd0,
        s_pop_byte    = 3'd1,
        s_send_start  = 3'd2,
        s_send_byte   = 3'd3,
        s_send_parity = 3'd4,
        s_send_stop   = 3'd5
    } tx_state_t;

    // Only the active word bits take part in parity; the rest are forced to 0.
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wl,
                                         input logic sp, input logic ep);
        logic [7:0] masked;
        logic       x;
        masked = data & (8'hFF >> (2'd3 - wl));
        x      = ^masked;
        case ({sp, ep})
            2'b00:   return ~x;
            2'b01:   return x;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Counter reload for the stop bit: 16, 24 (1.5 stop on 5-bit words) or 32 ticks.
    function automatic logic [4:0] stop_reload(input logic sb, input logic [1:0] wl);
        if (!sb) return 5'd15;
        return (wl == 2'b00) ? 5'd23 : 5'd31;
    endfunction

endpackage

// File: rtl/uart_transmitter_tfifo.sv
// 16-deep circular TX FIFO with occupancy count and sticky overrun flag.
module uart_tfifo
    import uart_transmitter_pkg::*;
(
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_fifo_reset,
    input  logic                           i_reset_status,
    input  logic [UART_FIFO_WIDTH-1:0]     i_data,
    output logic [UART_FIFO_WIDTH-1:0]     o_data,
    output logic [UART_FIFO_COUNTER_W-1:0] o_count,
    output logic                           o_overrun
);

    logic [UART_FIFO_WIDTH-1:0]     r_mem [UART_FIFO_DEPTH];
    logic [UART_FIFO_POINTER_W-1:0] r_top;
    logic [UART_FIFO_POINTER_W-1:0] r_bottom;
    logic [UART_FIFO_COUNTER_W-1:0] r_count;
    logic                           r_overrun;

    logic w_full, w_empty, w_do_pop, w_do_push, w_overrun;

    assign w_full    = (r_count == UART_FIFO_COUNTER_W'(UART_FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_overrun = i_push && w_full && !w_do_pop;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_top    <= '0;
            r_bottom <= '0;
            r_count  <= '0;
        end else if (i_fifo_reset) begin
            r_top    <= '0;
            r_bottom <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_top    <= r_top + 1'b1;
            if (w_do_pop)  r_bottom <= r_bottom + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_fifo_reset) r_mem[r_top] <= i_data;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)            r_overrun <= 1'b0;
        else if (w_overrun)      r_overrun <= 1'b1;
        else if (i_reset_status) r_overrun <= 1'b0;
    end

    assign o_data    = r_mem[r_bottom];
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_transmitter.sv
// UART 16550 transmit path: TX FIFO plus the serialiser FSM that frames each byte
// as start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_transmitter
    import uart_transmitter_pkg::*;
(
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic [7:0]                     lcr,
    input  logic                           tf_push,
    input  logic [7:0]                     wb_dat_i,
    input  logic                           enable,
    input  logic                           tx_reset,
    input  logic                           lsr_mask,
    output logic                           stx_pad_o,
    output logic [2:0]                     tstate,
    output logic [UART_FIFO_COUNTER_W-1:0] tf_count,
    output logic                           tf_overrun
);

    tx_state_t  r_state;
    logic [4:0] r_counter;
    logic [2:0] r_bit_counter;
    logic [7:0] r_shift_out;
    logic       r_parity;
    logic       r_stx_o_tmp;
    logic       r_tf_pop;

    logic [7:0] w_tf_data;
    logic       w_bit_end;
    logic [4:0] w_stop_reload;
    logic       w_unused_lcr;

    uart_tfifo u_tfifo (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .i_push         (tf_push),
        .i_pop          (r_tf_pop),
        .i_fifo_reset   (tx_reset),
        .i_reset_status (lsr_mask),
        .i_data         (wb_dat_i),
        .o_data         (w_tf_data),
        .o_count        (tf_count),
        .o_overrun      (tf_overrun)
    );

    assign w_bit_end     = enable && (r_counter == 5'd0);
    assign w_stop_reload = stop_reload(lcr[UART_LC_SB], lcr[1:0]);
    assign w_unused_lcr  = lcr[7];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= s_idle;
            r_counter     <= 5'd0;
            r_bit_counter <= 3'd0;
            r_shift_out   <= 8'd0;
            r_parity      <= 1'b0;
            r_stx_o_tmp   <= 1'b1;
            r_tf_pop      <= 1'b0;
        end else begin
            r_tf_pop <= 1'b0;
            // Bit-end branches below override this free-running decrement.
            if (enable) r_counter <= r_counter - 5'd1;
            case (r_state)
                s_idle: begin
                    r_stx_o_tmp <= 1'b1;
                    if (tf_count != '0) begin
                        r_tf_pop <= 1'b1;
                        r_state  <= s_pop_byte;
                    end
                end
                s_pop_byte: begin
                    r_shift_out   <= w_tf_data;
                    r_bit_counter <= {1'b1, lcr[1:0]};
                    r_parity      <= calc_parity(w_tf_data, lcr[1:0],
                                                 lcr[UART_LC_SP], lcr[UART_LC_EP]);
                    r_counter     <= 5'd15;
                    r_stx_o_tmp   <= 1'b0;
                    r_state       <= s_send_start;
                end
                s_send_start: begin
                    if (w_bit_end) begin
                        r_counter   <= 5'd15;
                        r_stx_o_tmp <= r_shift_out[0];
                        r_state     <= s_send_byte;
                    end
                end
                s_send_byte: begin
                    if (w_bit_end) begin
                        r_counter <= 5'd15;
                        if (r_bit_counter == 3'd0) begin
                            if (lcr[UART_LC_PE]) begin
                                r_stx_o_tmp <= r_parity;
                                r_state     <= s_send_parity;
                            end else begin
                                r_counter   <= w_stop_reload;
                                r_stx_o_tmp <= 1'b1;
                                r_state     <= s_send_stop;
                            end
                        end else begin
                            r_shift_out   <= r_shift_out >> 1;
                            r_bit_counter <= r_bit_counter - 3'd1;
                            r_stx_o_tmp   <= r_shift_out[1];
                        end
                    end
                end
                s_send_parity: begin
                    if (w_bit_end) begin
                        r_counter   <= w_stop_reload;
                        r_stx_o_tmp <= 1'b1;
                        r_state     <= s_send_stop;
                    end
                end
                s_send_stop: begin
                    r_stx_o_tmp <= 1'b1;
                    if (w_bit_end) begin
                        r_counter <= 5'd15;
                        r_state   <= s_idle;
                    end
                end
                default: begin
                    r_stx_o_tmp <= 1'b1;
                    r_state     <= s_idle;
                end
            endcase
        end
    end

    // Break forces the line low without disturbing the frame underneath.
    assign stx_pad_o = lcr[UART_LC_BC] ? 1'b0 : r_stx_o_tmp;
    assign tstate    = r_state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: pushes record expected frames; a tick-level monitor decodes
// the serial line against a frame model built from the LCR rules.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic [7:0] lcr;
    logic       tf_push = 1'b0;
    logic [7:0] wb_dat_i = 8'd0;
    logic       enable = 1'b0;
    logic       tx_reset = 1'b0;
    logic       lsr_mask = 1'b0;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic [4:0] tf_count;
    logic       tf_overrun;

    int n_checks = 0;
    int n_pass   = 0;
    bit en_run   = 1'b1;
    bit in_frame = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] lcr;
    } frame_t;
    typedef logic tick_q_t[$];

    frame_t exp_q[$];

    uart_transmitter dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .lcr        (lcr),
        .tf_push    (tf_push),
        .wb_dat_i   (wb_dat_i),
        .enable     (enable),
        .tx_reset   (tx_reset),
        .lsr_mask   (lsr_mask),
        .stx_pad_o  (stx_pad_o),
        .tstate     (tstate),
        .tf_count   (tf_count),
        .tf_overrun (tf_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference frame: one entry per 16x tick, line level expected during that tick.
    function automatic tick_q_t build_ticks(input frame_t f);
        tick_q_t q;
        int n, ones, stop;
        logic par;
        n = 5 + int'(f.lcr[1:0]);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(f.data[i]);
        if (f.lcr[5]) par = !f.lcr[4];
        else if (f.lcr[4]) par = (ones % 2) == 1;
        else par = (ones % 2) == 0;
        stop = !f.lcr[2] ? 16 : (n == 5 ? 24 : 32);
        repeat (16) q.push_back(1'b0);
        for (int i = 0; i < n; i++) repeat (16) q.push_back(f.data[i]);
        if (f.lcr[3]) repeat (16) q.push_back(par);
        repeat (stop) q.push_back(1'b1);
        return q;
    endfunction

    initial begin : enable_gen
        int ecnt = 0;
        forever begin
            @(posedge clk); #1;
            enable = en_run && (ecnt == 3);
            ecnt = (ecnt + 1) % 4;
        end
    end

    initial begin : monitor
        tick_q_t tq;
        frame_t  f;
        int pos = 0, tickn = 0, end_tick = 0, bad_pos = 0;
        bit b2b = 1'b0, bad = 1'b0;
        logic e_bit, bad_val;
        forever begin
            @(negedge clk);
            if (wb_rst_i) begin
                in_frame = 1'b0;
                b2b = 1'b0;
            end else if (enable) begin
                tickn++;
                if (!in_frame) begin
                    if (stx_pad_o === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL spurious_start: line low at tick %0d, nothing queued", tickn);
                        end else begin
                            f = exp_q.pop_front();
                            tq = build_ticks(f);
                            pos = 1;
                            bad = 1'b0;
                            in_frame = 1'b1;
                            if (b2b) check("b2b_gap_ticks", tickn - end_tick, 1);
                            b2b = 1'b0;
                        end
                    end
                end else begin
                    e_bit = lcr[6] ? 1'b0 : tq[pos];
                    if (!bad && stx_pad_o !== e_bit) begin
                        bad = 1'b1; bad_pos = pos; bad_val = stx_pad_o;
                    end
                    pos++;
                    if (pos == tq.size()) begin
                        n_checks++;
                        if (!bad) n_pass++;
                        else $display("FAIL frame_%02h_lcr_%02h: tick %0d line=%b expected=%b",
                                      f.data, f.lcr, bad_pos, bad_val, tq[bad_pos]);
                        check("stop_state_last_tick", tstate, 5);
                        @(posedge clk); #1;
                        check("idle_after_frame", tstate, 0);
                        in_frame = 1'b0;
                        b2b = (exp_q.size() != 0);
                        end_tick = tickn;
                    end
                end
            end
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        tf_push = 1'b1;
        wb_dat_i = d;
        if (accept) exp_q.push_back('{data: d, lcr: lcr});
        tick_clk(1);
        tf_push = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame || tstate != 3'd0) && t < 30000) begin
            tick_clk(1); t++;
        end
        if (t >= 30000) begin
            n_checks++;
            $display("FAIL idle_timeout: queued=%0d tstate=%0d", exp_q.size(), tstate);
        end
    endtask

    task automatic wait_tstate(input logic [2:0] s, input string name);
        int t = 0;
        while (tstate !== s && t < 5000) begin tick_clk(1); t++; end
        if (t >= 5000) begin
            n_checks++;
            $display("FAIL %s_timeout: tstate=%0d required %0d", name, tstate, s);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        wb_rst_i = 1'b1;
        lcr = 8'h03;
        tick_clk(3);
        check("rst_stx", stx_pad_o, 1);
        check("rst_tstate", tstate, 0);
        check("rst_tf_count", tf_count, 0);
        check("rst_tf_overrun", tf_overrun, 0);
        wb_rst_i = 1'b0;
        tick_clk(2);

        // 8N1, 5E1.5, then 7O2 back-to-back
        lcr = 8'h03; push(8'hA5, 1); wait_idle();
        lcr = 8'h1C; push(8'h1F, 1); wait_idle();
        lcr = 8'h0E; push(8'h00, 1); push(8'hFF, 1); wait_idle();

        // Stall the line so the FIFO fills behind a frame stuck in its start bit
        lcr = 8'h03; en_run = 1'b0; tick_clk(2);
        push(8'h3C, 1);
        tick_clk(4);
        check("stall_in_start", tstate, 2);
        for (int i = 0; i < 15; i++) push(8'($urandom), 1);
        check("count_15", tf_count, 15);
        push(8'($urandom), 1);
        check("count_full", tf_count, 16);
        check("no_overrun_at_16", tf_overrun, 0);
        lsr_mask = 1'b1;
        push(8'hEE, 0);
        lsr_mask = 1'b0;
        check("overrun_set_wins", tf_overrun, 1);
        check("count_after_overrun", tf_count, 16);
        lsr_mask = 1'b1; tick_clk(1); lsr_mask = 1'b0;
        check("overrun_cleared", tf_overrun, 0);
        en_run = 1'b1;
        // Push lands on the same edge as the FSM's pop of the full FIFO
        wait_tstate(3'd1, "first_pop");
        push(8'h77, 1);
        check("full_push_pop_no_overrun", tf_overrun, 0);
        check("full_push_pop_count", tf_count, 16);
        wait_idle();

        // tx_reset flushes queued bytes, frame in flight completes
        en_run = 1'b0;
        push(8'h81, 1);
        tick_clk(4);
        push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
        check("count_before_flush", tf_count, 3);
        tx_reset = 1'b1; tick_clk(1); tx_reset = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        check("count_after_flush", tf_count, 0);
        en_run = 1'b1;
        wait_idle();

        // Break mid-byte: line forced low, frame resumes in place
        lcr = 8'h03; push(8'h55, 1);
        wait_tstate(3'd3, "break_byte");
        tick_clk(20);
        lcr = 8'h43; #1;
        check("break_forces_low", stx_pad_o, 0);
        tick_clk(100);
        lcr = 8'h03;
        wait_idle();

        // Reset during a data bit with bytes still queued
        lcr = 8'h03; push(8'($urandom), 1);
        wait_tstate(3'd3, "reset_byte");
        push(8'h12, 1); push(8'h34, 1);
        tick_clk(10);
        wb_rst_i = 1'b1;
        exp_q.delete();
        #1;
        check("midframe_rst_stx", stx_pad_o, 1);
        check("midframe_rst_tstate", tstate, 0);
        check("midframe_rst_count", tf_count, 0);
        tick_clk(2);
        wb_rst_i = 1'b0;
        tick_clk(2);

        // Random word length, parity and stop configurations, single or paired frames
        for (int k = 0; k < 12; k++) begin
            lcr = {2'b00, 6'($urandom)};
            push(8'($urandom), 1);
            if ($urandom_range(0, 1) == 1) push(8'($urandom), 1);
            wait_idle();
        end

        tick_clk(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Transmit half of the UART 16550 core. Buffers bytes written by the Wishbone register block in a 16-entry FIFO, then serialises each byte onto `stx_pad_o` as start bit, 5–8 data bits LSB first, optional parity and 1/1.5/2 stop bits. All bit timing derives from the shared 16x-baud `enable` strobe. It pairs with the receiver on the opposite pad and shares its LCR encoding.

## Interface
- `UART_FIFO_WIDTH` (define): default 8. FIFO data width.
- `UART_FIFO_DEPTH` (define): default 16. FIFO depth.
- `UART_FIFO_COUNTER_W` (define): default 5. Width of the FIFO count.

- `clk` input 1: system clock.
- `wb_rst_i` input 1: asynchronous, active-high reset.
- `lcr` input 8: line control. [1:0] word length 5/6/7/8; [2] stop bits; [3] PE; [4] EP; [5] SP; [6] break.
- `tf_push` input 1: one-cycle pulse that writes `wb_dat_i` into the TX FIFO.
- `wb_dat_i` input 8: byte to enqueue.
- `enable` input 1: 16x baud tick, one `clk` wide.
- `tx_reset` input 1: synchronous FIFO flush.
- `lsr_mask` input 1: clears the sticky `tf_overrun`.
- `stx_pad_o` output 1: serial line. Reset value is 1.
- `tstate` output 3: current FSM state, for the LSR TEMT/THRE logic. Reset value is 0.
- `tf_count` output `UART_FIFO_COUNTER_W`: FIFO occupancy. Reset value is 0.
- `tf_overrun` output 1: sticky flag, set by a push while the FIFO is full. Reset value is 0.

## Operation
- FSM states:
  - `s_idle`=0
  - `s_pop_byte`=1
  - `s_send_start`=2
  - `s_send_byte`=3
  - `s_send_parity`=4
  - `s_send_stop`=5
  - Codes 6–7 go to `s_idle`.
- `s_idle`:
  - `stx_o_tmp`=1.
  - If `tf_count`≠0, pulse the internal `tf_pop` for one cycle and go to `s_pop_byte`.
  - `enable` is not required to leave this state.
- `s_pop_byte`:
  - Latch the FIFO head into `shift_out`.
  - Load `bit_counter` = word length − 1 (4..7).
  - Compute parity:
    - PE=0: none.
    - SP=0, EP=0 (odd): `~^data`.
    - SP=0, EP=1 (even): `^data`.
    - SP=1, EP=0: 1.
    - SP=1, EP=1: 0.
  - Parity covers only the active word bits; bits above the word length are masked to 0.
  - Load `counter` = 15, then go to `s_send_start`.
- Bit timing:
  - Every serial bit lasts exactly 16 `enable` ticks.
  - `counter` is 5 bits and decrements on `enable`.
  - A bit ends on an `enable` while `counter`==0, which also reloads `counter`.
- `s_send_start`: `stx_o_tmp`=0. At end of bit go to `s_send_byte`.
- `s_send_byte`:
  - `stx_o_tmp`=`shift_out[0]`.
  - At end of bit, shift right and decrement `bit_counter`.
  - When `bit_counter` was 0, go to `s_send_parity` if PE=1, else `s_send_stop`.
- `s_send_parity`: drive the parity bit, then go to `s_send_stop`.
- `s_send_stop`:
  - `stx_o_tmp`=1.
  - Duration:
    - `lcr[2]`=0: 16 ticks.
    - `lcr[2]`=1 with 5-bit words: 24 ticks.
    - `lcr[2]`=1 otherwise: 32 ticks.
  - Then go to `s_idle`.
- `stx_pad_o` = `lcr[6] ? 0 : stx_o_tmp`:
  - Break overrides the line combinationally.
  - The FSM keeps running underneath.
- `lcr` is sampled live. Software must not change it mid-frame; doing so is undefined but must not lock the FSM.
- FIFO rules:
  - Push while full: data is dropped and `tf_overrun` is set.
  - Push and pop in the same cycle on a full FIFO are both honoured, with no overrun.
  - `tx_reset` empties the FIFO and zeroes `tf_count` next cycle. It does not abort the frame in flight.
  - `lsr_mask` clears `tf_overrun`. If `lsr_mask` and an overrunning push coincide, the set wins.
- Reset asserted mid-frame: immediate return to idle and line high (`stx_pad_o`=1), with the FIFO emptied.

## Timing
- Pop latency: data is in `shift_out` 2 `clk` after `tf_count` becomes non-zero in `s_idle`.
- The start bit appears on `stx_pad_o` from that point; its 16-tick duration is counted from the next `enable`.
- Frame length in ticks: 16·(1 + N + PE) + stop ticks. 8N1 = 160 ticks.
- Back-to-back frames: the next start bit follows the stop bit within 2 `clk`, with no extra idle ticks.
- `tstate` and `tf_count` are registered; `stx_pad_o` is registered except for the break mux.

## Structure
- State codes, LCR bit indices (`UART_LC_PE`, `UART_LC_EP`, `UART_LC_SP`, `UART_LC_SB`, `UART_LC_BC`) and FIFO width/depth/counter defines live in the shared `uart_defines.v`.
- One sub-module: `uart_tfifo`, an 8-bit wide, 16-deep circular buffer with push/pop/count/overrun/reset_status.
- The FSM, counters and parity logic are local to `uart_transmitter`.

## Test plan
- 8N1, push 0xA5, `enable` every 4 clk:
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 ticks.
  - `tstate` returns to 0 after 160 ticks.
- 5-bit, even parity, `lcr[2]`=1, push 0x1F:
  - Data 1,1,1,1,1, parity 1, stop high for 24 ticks.
- 17 pushes with no `enable`:
  - `tf_count`=16 and `tf_overrun`=1.
  - The 17th byte is never transmitted.
  - `lsr_mask` clears the flag.
- Set `lcr[6]` mid-byte of 0x55:
  - `stx_pad_o` goes low immediately.
  - When `lcr[6]` clears, the line resumes at the correct bit position of the frame.
- Assert `wb_rst_i` during a data bit:
  - `stx_pad_o`=1, `tstate`=0 and `tf_count`=0 in the same cycle.
- Push 0x00, 0xFF back-to-back, 7O2:
  - Two frames with parity bits 1 and 0, each with 32-tick stop, and no gap between the frames.
